// File: rtl/axi_pkg.sv
// axi_pkg: AXI3 field widths, encodings and the read-slave state type, shared by the read/write slaves.
package axi_pkg;

    localparam int unsigned LEN_W   = 4;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned BURST_W = 2;
    localparam int unsigned LOCK_W  = 2;
    localparam int unsigned CACHE_W = 4;
    localparam int unsigned PROT_W  = 3;
    localparam int unsigned RESP_W  = 2;

    localparam logic [BURST_W-1:0] BURST_FIXED = 2'b00;
    localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;
    localparam logic [BURST_W-1:0] BURST_WRAP  = 2'b10;
    localparam logic [BURST_W-1:0] BURST_RSVD  = 2'b11;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_EXOKAY = 2'b01;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

    localparam logic [LOCK_W-1:0] LOCK_EXCL = 2'b01;

    // Widest supported beat on a 32-bit bus is 4 bytes (size code 2)
    localparam logic [SIZE_W-1:0] SIZE_MAX = 3'd2;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_FETCH = 2'd1,
        RD_CAPT  = 2'd2,
        RD_SEND  = 2'd3
    } rd_state_e;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats
    function automatic logic wrap_len_ok(input logic [LEN_W-1:0] len);
        return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: next beat address for FIXED / INCR / WRAP bursts (purely combinational).
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0]  cur_addr,
    input  logic [SIZE_W-1:0]  size,
    input  logic [LEN_W-1:0]   len,
    input  logic [BURST_W-1:0] burst,
    output logic [ADDR_W-1:0]  next_addr_c
);

    logic [ADDR_W-1:0] size_bytes;
    logic [ADDR_W-1:0] wrap_bytes;
    logic [ADDR_W-1:0] step_addr;

    // INCR aligns down then steps; WRAP steps and folds back inside the wrap window
    always_comb begin
        size_bytes  = ADDR_W'(1) << size;
        wrap_bytes  = ADDR_W'({1'b0, len} + 5'd1) << size;
        step_addr   = cur_addr + size_bytes;
        next_addr_c = cur_addr;
        case (burst)
            BURST_INCR: next_addr_c = (cur_addr & ~(size_bytes - ADDR_W'(1))) + size_bytes;
            BURST_WRAP: next_addr_c = (cur_addr & ~(wrap_bytes - ADDR_W'(1)))
                                    | (step_addr & (wrap_bytes - ADDR_W'(1)));
            default:    next_addr_c = cur_addr;
        endcase
    end

endmodule

// File: rtl/axi_read_slave.sv
// axi_read_slave: AXI3 read responder, one burst at a time, in front of a 1-cycle-latency memory.
// Build option: AXI_RD_EXCL_EN makes exclusive (ARLOCK=01) good bursts answer EXOKAY.
module axi_read_slave
    import axi_pkg::*;
#(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic               ACLK,
    input  logic               ARESETn,
    input  logic [ID_W-1:0]    ARID,
    input  logic [ADDR_W-1:0]  ARADDR,
    input  logic [LEN_W-1:0]   ARLEN,
    input  logic [SIZE_W-1:0]  ARSIZE,
    input  logic [BURST_W-1:0] ARBURST,
    input  logic [LOCK_W-1:0]  ARLOCK,
    input  logic [CACHE_W-1:0] ARCACHE,
    input  logic [PROT_W-1:0]  ARPROT,
    input  logic               ARVALID,
    output logic               ARREADY,
    output logic [ID_W-1:0]    RID,
    output logic [DATA_W-1:0]  RDATA,
    output logic [RESP_W-1:0]  RRESP,
    output logic               RLAST,
    output logic               RVALID,
    input  logic               RREADY,
    output logic               mem_rd_req,
    output logic [ADDR_W-1:0]  mem_rd_addr,
    input  logic [DATA_W-1:0]  mem_rd_data,
    output logic               readbusy
);

    rd_state_e          state_q, next_state;
    logic [ADDR_W-1:0]  addr_q, addr_d, next_addr_c, mem_rd_addr_q;
    logic [LEN_W-1:0]   len_q, cnt_q, cnt_d;
    logic [SIZE_W-1:0]  size_q;
    logic [BURST_W-1:0] burst_q;
    logic               err_q;
    logic               arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic               mem_rd_req_q, mem_rd_req_d, readbusy_q, readbusy_d;
    logic [ID_W-1:0]    rid_q;
    logic [DATA_W-1:0]  rdata_q;
    logic [RESP_W-1:0]  rresp_q, ar_resp_c;
    logic               ar_hs_c, r_hs_c, last_c, ar_err_c;
    logic               unused_ok;

    assign ar_hs_c  = ARVALID & arready_q;
    assign r_hs_c   = rvalid_q & RREADY;
    assign last_c   = (cnt_q == '0);
    assign ar_err_c = (ARBURST == BURST_RSVD) || (ARSIZE > SIZE_MAX)
                   || ((ARBURST == BURST_WRAP) && !wrap_len_ok(ARLEN));
    assign unused_ok = ^{ARCACHE, ARPROT, ARLOCK};

    // Response code chosen once at acceptance and held for the whole burst
    always_comb begin
        ar_resp_c = RESP_OKAY;
`ifdef AXI_RD_EXCL_EN
        if (ARLOCK == LOCK_EXCL) ar_resp_c = RESP_EXOKAY;
`endif
        if (ar_err_c) ar_resp_c = RESP_SLVERR;
    end

    axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .cur_addr    (addr_q),
        .size        (size_q),
        .len         (len_q),
        .burst       (burst_q),
        .next_addr_c (next_addr_c)
    );

    // State register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state_q <= RD_IDLE;
        else          state_q <= next_state;
    end

    // Next-state logic; error bursts skip the memory and stream straight from SEND
    always_comb begin
        next_state = state_q;
        case (state_q)
            RD_IDLE:  if (ar_hs_c) next_state = ar_err_c ? RD_SEND : RD_FETCH;
            RD_FETCH: next_state = RD_CAPT;
            RD_CAPT:  next_state = RD_SEND;
            RD_SEND:  if (r_hs_c) next_state = last_c ? RD_IDLE : (err_q ? RD_SEND : RD_FETCH);
            default:  next_state = RD_IDLE;
        endcase
    end

    // Output/datapath next values, decoded from the next state so registers line up with it
    always_comb begin
        cnt_d  = cnt_q;
        addr_d = addr_q;
        if (ar_hs_c) begin
            cnt_d  = ARLEN;
            addr_d = ARADDR;
        end else if (r_hs_c && !last_c) begin
            cnt_d  = cnt_q - LEN_W'(1);
            addr_d = next_addr_c;
        end
        arready_d    = (next_state == RD_IDLE);
        rvalid_d     = (next_state == RD_SEND);
        rlast_d      = (next_state == RD_SEND) && (cnt_d == '0);
        mem_rd_req_d = (next_state == RD_FETCH);
        readbusy_d   = (next_state != RD_IDLE);
    end

    // Burst context, beat counter and registered outputs
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            cnt_q         <= '0;
            addr_q        <= '0;
            len_q         <= '0;
            size_q        <= '0;
            burst_q       <= '0;
            err_q         <= 1'b0;
            arready_q     <= 1'b1;
            rvalid_q      <= 1'b0;
            rlast_q       <= 1'b0;
            mem_rd_req_q  <= 1'b0;
            mem_rd_addr_q <= '0;
            readbusy_q    <= 1'b0;
            rid_q         <= '0;
            rdata_q       <= '0;
            rresp_q       <= RESP_OKAY;
        end else begin
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            arready_q    <= arready_d;
            rvalid_q     <= rvalid_d;
            rlast_q      <= rlast_d;
            mem_rd_req_q <= mem_rd_req_d;
            readbusy_q   <= readbusy_d;
            if (mem_rd_req_d) mem_rd_addr_q <= addr_d;
            if (ar_hs_c) begin
                len_q   <= ARLEN;
                size_q  <= ARSIZE;
                burst_q <= ARBURST;
                err_q   <= ar_err_c;
                rid_q   <= ARID;
                rresp_q <= ar_resp_c;
                if (ar_err_c) rdata_q <= '0;
            end else if (state_q == RD_CAPT) begin
                rdata_q <= mem_rd_data;
            end
        end
    end

    assign ARREADY     = arready_q;
    assign RVALID      = rvalid_q;
    assign RLAST       = rlast_q;
    assign RID         = rid_q;
    assign RDATA       = rdata_q;
    assign RRESP       = rresp_q;
    assign mem_rd_req  = mem_rd_req_q;
    assign mem_rd_addr = mem_rd_addr_q;
    assign readbusy    = readbusy_q;

endmodule

// File: tb/tb_axi_read_slave.sv
// tb_axi_read_slave: directed table, hand-written reset sequences and randomized bursts vs. a burst model.
module tb_axi_read_slave;

    localparam logic [1:0] R_OK = 2'b00;
    localparam logic [1:0] R_SE = 2'b10;
`ifdef AXI_RD_EXCL_EN
    localparam logic [1:0] R_EX = 2'b01;
`else
    localparam logic [1:0] R_EX = 2'b00;
`endif

    logic        ACLK, ARESETn;
    logic [3:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST, ARLOCK;
    logic [3:0]  ARCACHE;
    logic [2:0]  ARPROT;
    logic        ARVALID, ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST, RVALID, RREADY;
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr, mem_rd_data;
    logic        readbusy;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_addr [16];

    axi_read_slave dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .readbusy(readbusy)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Memory contents as a function of the word address; bits [1:0] are ignored
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        logic [31:0] w;
        w = a >> 2;
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Data valid one cycle after the request; junk otherwise
    always @(posedge ACLK) mem_rd_data <= mem_rd_req ? mem_f(mem_rd_addr) : 32'($urandom);

    // Reference: address of beat i computed directly from the burst rules
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [3:0] len,
                                              input logic [2:0] size, input logic [1:0] burst, input int i);
        logic [31:0] sb, wb, base;
        sb = 32'd1 << size;
        wb = (32'(len) + 32'd1) << size;
        if (burst == 2'b00 || i == 0) return a;
        if (burst == 2'b01) return (a - (a % sb)) + 32'(i) * sb;
        base = a - (a % wb);
        return base + (((a - base) + 32'(i) * sb) % wb);
    endfunction

    function automatic bit is_err(input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
        return (burst == 2'b11) || (size > 3'd2) || (burst == 2'b10 && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}));
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
        end
    endtask

    // Issue one AR and run the burst to completion; mode 0: RREADY=1, 1: 1-0-0-1 pattern, 2: random
    task automatic run_burst(input string tag, input logic [3:0] id, input logic [31:0] addr,
                             input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst,
                             input logic [1:0] lock, input int mode, input logic [1:0] eresp);
        int nbeat, nfetch, cyc, vidx, last_acc, budget, ar_viol, busy_viol;
        bit err, done, held, rr;
        logic [38:0] hold_v;
        err = (eresp == R_SE);
        nbeat = 0; nfetch = 0; vidx = 0; last_acc = -1; ar_viol = 0; busy_viol = 0;
        held = 0; done = 0; hold_v = '0;
        budget = 40 * (int'(len) + 1) + 20;
        @(negedge ACLK);
        chk({tag, " arready_idle"}, 64'(ARREADY), 64'd1);
        ARVALID = 1'b1; ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
        ARLOCK = lock; ARCACHE = 4'($urandom); ARPROT = 3'($urandom);
        @(negedge ACLK);
        ARVALID = 1'b0; ARID = 4'($urandom); ARADDR = $urandom; ARLEN = 4'($urandom);
        ARSIZE = 3'($urandom); ARBURST = 2'($urandom); ARLOCK = 2'($urandom);
        cyc = 1;
        while (!done && cyc <= budget) begin
            if (ARREADY !== 1'b0) ar_viol++;
            if (readbusy !== 1'b1) busy_viol++;
            if (mem_rd_req === 1'b1) begin
                if (nfetch == 0 && !err) chk({tag, " first_req_cycle"}, 64'(cyc), 64'd1);
                if (!err && nfetch < 16)
                    chk($sformatf("%s fetch%0d addr", tag, nfetch), 64'(mem_rd_addr), 64'(exp_addr[nfetch]));
                nfetch++;
            end
            if (held) begin
                chk({tag, " stall_valid"}, 64'(RVALID), 64'd1);
                chk({tag, " stall_hold"}, 64'({RDATA, RRESP, RLAST, RID}), 64'(hold_v));
            end
            case (mode)
                0:       rr = 1'b1;
                1:       rr = (vidx % 4 == 0) || (vidx % 4 == 3);
                default: rr = ($urandom_range(0, 2) != 0);
            endcase
            RREADY = rr;
            held = 0;
            if (RVALID === 1'b1) begin
                vidx++;
                if (rr) begin
                    chk($sformatf("%s beat%0d data", tag, nbeat), 64'(RDATA),
                        64'(err ? 32'd0 : mem_f(exp_addr[nbeat])));
                    chk($sformatf("%s beat%0d resp", tag, nbeat), 64'(RRESP), 64'(eresp));
                    chk($sformatf("%s beat%0d last", tag, nbeat), 64'(RLAST), 64'(nbeat == int'(len)));
                    chk($sformatf("%s beat%0d id", tag, nbeat), 64'(RID), 64'(id));
                    if (mode == 0 && last_acc >= 0)
                        chk($sformatf("%s beat%0d gap", tag, nbeat), 64'(cyc - last_acc), 64'(err ? 1 : 3));
                    last_acc = cyc;
                    nbeat++;
                    if (nbeat == int'(len) + 1) done = 1;
                end else begin
                    held = 1;
                    hold_v = {RDATA, RRESP, RLAST, RID};
                end
            end
            @(negedge ACLK);
            cyc++;
        end
        chk({tag, " completed"}, 64'(done), 64'd1);
        chk({tag, " beat_count"}, 64'(nbeat), 64'(int'(len) + 1));
        chk({tag, " fetch_count"}, 64'(nfetch), 64'(err ? 0 : int'(len) + 1));
        chk({tag, " arready_low_busy"}, 64'(ar_viol), 64'd0);
        chk({tag, " readbusy_high"}, 64'(busy_viol), 64'd0);
        chk({tag, " arready_after"}, 64'(ARREADY), 64'd1);
        chk({tag, " idle_after"}, 64'({readbusy, RVALID}), 64'd0);
    endtask

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [1:0]  lock;
        int          mode;
        logic [1:0]  resp;
        logic [31:0] a0, a1, a2, a3;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int nb;
        int viol;
        logic [3:0]  r_len;
        logic [2:0]  r_size;
        logic [1:0]  r_burst, r_lock;
        logic [31:0] r_addr;

        tbl[0]  = '{4'h3, 32'h0000_0100, 4'd3, 3'd2, 2'b01, 2'b00, 0, R_OK, 32'h100, 32'h104, 32'h108, 32'h10C};
        tbl[1]  = '{4'h7, 32'h0000_0038, 4'd3, 3'd2, 2'b10, 2'b00, 0, R_OK, 32'h38, 32'h3C, 32'h30, 32'h34};
        tbl[2]  = '{4'h1, 32'h0000_0200, 4'd2, 3'd2, 2'b00, 2'b00, 1, R_OK, 32'h200, 32'h200, 32'h200, 32'h0};
        tbl[3]  = '{4'hA, 32'h0000_0300, 4'd1, 3'd2, 2'b11, 2'b00, 0, R_SE, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[4]  = '{4'h5, 32'h0000_0040, 4'd0, 3'd2, 2'b01, 2'b01, 0, R_EX, 32'h40, 32'h0, 32'h0, 32'h0};
        tbl[5]  = '{4'h2, 32'h0000_0500, 4'd0, 3'd3, 2'b01, 2'b00, 0, R_SE, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[6]  = '{4'hC, 32'h0000_0600, 4'd2, 3'd2, 2'b10, 2'b00, 0, R_SE, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[7]  = '{4'h9, 32'h0000_0103, 4'd3, 3'd0, 2'b01, 2'b00, 1, R_OK, 32'h103, 32'h104, 32'h105, 32'h106};
        tbl[8]  = '{4'h4, 32'h0000_0102, 4'd2, 3'd2, 2'b01, 2'b00, 0, R_OK, 32'h102, 32'h104, 32'h108, 32'h0};
        tbl[9]  = '{4'hE, 32'h0000_000A, 4'd3, 3'd1, 2'b10, 2'b00, 0, R_OK, 32'h0A, 32'h0C, 32'h0E, 32'h08};
        tbl[10] = '{4'hF, 32'hFFFF_FFFC, 4'd1, 3'd2, 2'b01, 2'b01, 0, R_EX, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0};
        tbl[11] = '{4'h6, 32'h0000_1000, 4'd3, 3'd4, 2'b10, 2'b01, 0, R_SE, 32'h0, 32'h0, 32'h0, 32'h0};

        ARESETn = 1'b0; ARVALID = 1'b0; ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0;
        ARBURST = '0; ARLOCK = '0; ARCACHE = '0; ARPROT = '0; RREADY = 1'b0;
        repeat (3) @(negedge ACLK);
        chk("reset arready", 64'(ARREADY), 64'd1);
        chk("reset rvalid", 64'(RVALID), 64'd0);
        chk("reset rlast", 64'(RLAST), 64'd0);
        chk("reset rid", 64'(RID), 64'd0);
        chk("reset rdata", 64'(RDATA), 64'd0);
        chk("reset rresp", 64'(RRESP), 64'd0);
        chk("reset mem_rd_req", 64'(mem_rd_req), 64'd0);
        chk("reset mem_rd_addr", 64'(mem_rd_addr), 64'd0);
        chk("reset readbusy", 64'(readbusy), 64'd0);
        ARESETn = 1'b1;

        // Directed table
        for (int t = 0; t < 12; t++) begin
            exp_addr[0] = tbl[t].a0; exp_addr[1] = tbl[t].a1;
            exp_addr[2] = tbl[t].a2; exp_addr[3] = tbl[t].a3;
            run_burst($sformatf("vec%0d", t), tbl[t].id, tbl[t].addr, tbl[t].len, tbl[t].size,
                      tbl[t].burst, tbl[t].lock, tbl[t].mode, tbl[t].resp);
        end

        // Reset during beat 2 of an 8-beat burst
        @(negedge ACLK);
        RREADY = 1'b1; ARVALID = 1'b1; ARID = 4'h5; ARADDR = 32'h400; ARLEN = 4'd7;
        ARSIZE = 3'd2; ARBURST = 2'b01; ARLOCK = 2'b00;
        @(negedge ACLK);
        ARVALID = 1'b0;
        nb = 0;
        for (int n = 0; n < 100 && nb < 2; n++) begin
            if (RVALID === 1'b1) nb++;
            if (nb < 2) @(negedge ACLK);
        end
        chk("rst_mid reached_beat2", 64'(nb), 64'd2);
        ARESETn = 1'b0;
        #1;
        chk("rst_mid rvalid", 64'(RVALID), 64'd0);
        chk("rst_mid arready", 64'(ARREADY), 64'd1);
        chk("rst_mid mem_rd_req", 64'(mem_rd_req), 64'd0);
        chk("rst_mid readbusy", 64'(readbusy), 64'd0);
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        viol = 0;
        repeat (8) begin
            @(negedge ACLK);
            if (RVALID !== 1'b0 || mem_rd_req !== 1'b0 || readbusy !== 1'b0) viol++;
        end
        chk("rst_mid no_resume", 64'(viol), 64'd0);
        exp_addr[0] = 32'h0000_0800;
        run_burst("post_rst", 4'hB, 32'h0000_0800, 4'd0, 3'd2, 2'b01, 2'b00, 0, R_OK);

        // Randomized bursts against the reference model
        for (int i = 0; i < 40; i++) begin
            r_addr  = $urandom;
            r_len   = 4'($urandom);
            r_size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            r_burst = 2'($urandom);
            r_lock  = 2'($urandom);
            if (r_burst == 2'b10 && $urandom_range(0, 3) != 0) r_len = 4'((2 << $urandom_range(0, 3)) - 1);
            for (int b = 0; b < 16; b++) exp_addr[b] = beat_addr(r_addr, r_len, r_size, r_burst, b);
            run_burst($sformatf("rnd%0d", i), 4'($urandom), r_addr, r_len, r_size, r_burst, r_lock,
                      $urandom_range(0, 2),
                      is_err(r_len, r_size, r_burst) ? R_SE : ((r_lock == 2'b01) ? R_EX : R_OK));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
